fir_coeff_update_ctrl: RTL and testbench

- Sequences a coefficient reload of the FIR filter's 33-tap coefficient SRAM and generates the filter's 300 kHz sample enable from the 12 MHz clock.
- Accepts a stream of 16-bit coefficients over a valid/ready handshake from the host/config path.
- Aligns the start of each reload to a sample boundary and drives the filter's iCoeffiUpdateFlag/iCsnRam/iWrnRam/iAddrRam/iWrDtRam pins.
- Masks sample strobes while a reload is in progress and counts the strobes it drops.

---
 rtl/fir_coeff_update_ctrl.sv | 149 ++++++++++++++
 tb/tb_fir_coeff_update_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_update_ctrl.sv
// fir_coeff_update_ctrl: reloads the FIR coefficient SRAM on a sample boundary and
// generates the 300 kHz sample enable, masking and counting strobes during a reload.
module fir_coeff_update_ctrl #(
    parameter int P_DIV       = 40,
    parameter int P_TAPS      = 33,
    parameter int P_ADDR_BASE = 1,
    parameter int P_TIMEOUT   = 64
) (
    input  logic        iClk_12M,
    input  logic        iRst,
    input  logic        iUpdReq,
    input  logic        iCoefValid,
    input  logic [15:0] iCoefData,
    output logic        oCoefReady,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr,
    output logic [7:0]  oDropCnt,
    output logic        oEnSample_300k,
    output logic        oCoeffiUpdateFlag,
    output logic        oCsnRam,
    output logic        oWrnRam,
    output logic [5:0]  oAddrRam,
    output logic [15:0] oWrDtRam
);
    localparam int DW = $clog2(P_DIV);
    localparam int KW = $clog2(P_TAPS + 1);
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALIGN = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    if (P_ADDR_BASE + P_TAPS - 1 > 63) begin : g_addr_check
        $error("coefficient addresses exceed the 6-bit SRAM address range");
    end

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [KW-1:0] k_q, k_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    drop_q, drop_d;
    logic [5:0]    addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          err_q, err_d, en_q, en_d, ready_q, ready_d, busy_q, busy_d;
    logic          done_q, done_d, flag_q, flag_d, csn_q, csn_d, wrn_q, wrn_d;
    logic          raw, hs, strobe_d, masked_d;

    // Every output is registered from next-state values so it lines up with the state it belongs to.
    always_comb begin
        raw     = div_q == DW'(P_DIV - 1);
        hs      = iCoefValid & ready_q;
        div_d   = raw ? '0 : div_q + 1'b1;
        state_d = state_q;
        k_d     = k_q;
        to_d    = to_q;
        err_d   = err_q;
        csn_d   = 1'b1;
        wrn_d   = 1'b1;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: if (iUpdReq) begin
                state_d = S_ALIGN;
                k_d     = '0;
                to_d    = '0;
                err_d   = 1'b0;
            end
            S_ALIGN: if (raw) state_d = S_WRITE;
            S_WRITE: if (hs) begin
                csn_d  = 1'b0;
                wrn_d  = 1'b0;
                addr_d = 6'(P_ADDR_BASE) + 6'(k_q);
                data_d = iCoefData;
                k_d    = k_q + 1'b1;
                to_d   = '0;
            end else if (k_q == KW'(P_TAPS)) begin
                state_d = S_FLUSH;
            end else if (to_q == TW'(P_TIMEOUT - 1)) begin
                state_d = S_FLUSH;
                err_d   = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_FLUSH) begin
            addr_d = '0;
            data_d = '0;
        end
        strobe_d = div_d == DW'(P_DIV - 1);
        masked_d = (state_d == S_WRITE) | (state_d == S_FLUSH);
        en_d     = strobe_d & ~masked_d;
        drop_d   = (state_q == S_IDLE && iUpdReq) ? '0 :
                   (strobe_d && masked_d && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
        ready_d  = state_d == S_WRITE && k_d != KW'(P_TAPS);
        flag_d   = state_d == S_WRITE;
        busy_d   = state_d != S_IDLE;
        done_d   = state_q == S_FLUSH && !err_q;
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            k_q     <= '0;
            to_q    <= '0;
            drop_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            k_q     <= k_d;
            to_q    <= to_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            flag_q  <= flag_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
        end
    end

    assign oCoefReady        = ready_q;
    assign oBusy             = busy_q;
    assign oDone             = done_q;
    assign oErr              = err_q;
    assign oDropCnt          = drop_q;
    assign oEnSample_300k    = en_q;
    assign oCoeffiUpdateFlag = flag_q;
    assign oCsnRam           = csn_q;
    assign oWrnRam           = wrn_q;
    assign oAddrRam          = addr_q;
    assign oWrDtRam          = data_q;
endmodule

// File: tb/tb_fir_coeff_update_ctrl.sv
// tb_fir_coeff_update_ctrl: timeline-based reference model of the reload controller,
// driven by a scenario table, randomized handshakes and hand-written corner sequences.
module tb_fir_coeff_update_ctrl;
    localparam int INF = 1 << 30;

    logic        clk, iRst, iUpdReq, iCoefValid;
    logic [15:0] iCoefData;
    logic        oCoefReady, oBusy, oDone, oErr, oEnSample_300k, oCoeffiUpdateFlag, oCsnRam, oWrnRam;
    logic [7:0]  oDropCnt;
    logic [5:0]  oAddrRam;
    logic [15:0] oWrDtRam;

    fir_coeff_update_ctrl dut (
        .iClk_12M(clk), .iRst(iRst), .iUpdReq(iUpdReq), .iCoefValid(iCoefValid),
        .iCoefData(iCoefData), .oCoefReady(oCoefReady), .oBusy(oBusy), .oDone(oDone),
        .oErr(oErr), .oDropCnt(oDropCnt), .oEnSample_300k(oEnSample_300k),
        .oCoeffiUpdateFlag(oCoeffiUpdateFlag), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam),
        .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0, wr_seen = 0, done_seen = 0;
    // Reload timeline: request cycle, first WRITE cycle, FLUSH cycle, handshakes so far.
    int n, a_cyc, w0, fl, k, miss, last_hs, drops;
    bit aborted, err_m;
    logic [5:0]  addr_e;
    logic [15:0] data_e, last_word;

    typedef struct {
        int mode;
        bit upd_wr;
        bit vld_idle;
        int exp_wr;
        int exp_done;
        bit exp_err;
    } scn_t;
    scn_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, n, act, exp);
        end
    endtask

    function automatic bit grid(input int c);
        return (c % 40) == 39;
    endfunction

    function automatic bit busy_e(input int c);
        return a_cyc >= 0 && c > a_cyc && c <= fl;
    endfunction

    function automatic bit flag_e(input int c);
        return a_cyc >= 0 && c >= w0 && c < fl;
    endfunction

    function automatic bit ready_e(input int c);
        return flag_e(c) && k < 33;
    endfunction

    task automatic mreset();
        n = 0; a_cyc = -1; w0 = INF; fl = -1; k = 0; miss = 0; last_hs = -10;
        drops = 0; aborted = 0; err_m = 0; addr_e = '0; data_e = '0; last_word = '0;
    endtask

    task automatic model_upd(input bit req, input bit vld, input logic [15:0] dat);
        if (!busy_e(n) && req) begin
            a_cyc = n;
            w0 = n + 1 + (39 - (n + 1) % 40) + 1;
            fl = INF; k = 0; miss = 0; aborted = 0;
        end else if (ready_e(n)) begin
            if (vld) begin
                k++; miss = 0; last_hs = n; last_word = dat;
                if (k == 33) fl = n + 2;
            end else begin
                miss++;
                if (miss == 64) begin
                    fl = n + 1;
                    aborted = 1;
                end
            end
        end
        n++;
    endtask

    task automatic model_chk();
        bit in_mask, wr;
        if (n == a_cyc + 1) begin
            drops = 0;
            err_m = 0;
        end
        in_mask = a_cyc >= 0 && n >= w0 && n <= fl;
        if (grid(n) && in_mask && drops < 255) drops++;
        if (aborted && n == fl) err_m = 1;
        wr = n == last_hs + 1;
        if (wr) begin
            addr_e = 6'(k);
            data_e = last_word;
        end
        if (n == fl) begin
            addr_e = '0;
            data_e = '0;
        end
        chk("en", oEnSample_300k, grid(n) && !in_mask);
        chk("busy", oBusy, busy_e(n));
        chk("ready", oCoefReady, ready_e(n));
        chk("flag", oCoeffiUpdateFlag, flag_e(n));
        chk("done", oDone, !aborted && a_cyc >= 0 && fl != INF && n == fl + 1);
        chk("err", oErr, err_m);
        chk("drop", oDropCnt, drops);
        chk("csn", oCsnRam, !wr);
        chk("wrn", oWrnRam, !wr);
        chk("addr", oAddrRam, addr_e);
        chk("data", oWrDtRam, data_e);
    endtask

    task automatic step(input bit rst, input bit req, input bit vld, input logic [15:0] dat);
        iRst = rst; iUpdReq = req; iCoefValid = vld; iCoefData = dat;
        if (rst) mreset();
        else model_upd(req, vld, dat);
        @(posedge clk);
        #1;
        model_chk();
        if (oCsnRam === 1'b0) wr_seen++;
        if (oDone === 1'b1) done_seen++;
    endtask

    task automatic run_scn(input scn_t s);
        logic [15:0] coef[33];
        logic [15:0] dat;
        bit vld, upd;
        int wr0, dn0, guard;
        for (int i = 0; i < 33; i++) coef[i] = (s.mode == 3) ? 16'($urandom) : 16'(i + 3);
        wr0 = wr_seen;
        dn0 = done_seen;
        repeat ($urandom_range(0, 45)) step(0, 0, s.vld_idle ? 1'($urandom) : 1'b0, 16'($urandom));
        step(0, 1, 0, 16'h0);
        guard = 0;
        while (n <= fl + 1 && guard < 3000) begin
            case (s.mode)
                0: vld = 1'b1;
                1: vld = (n % 2) == 0;
                2: vld = k < 10;
                default: vld = $urandom_range(0, 9) < 7;
            endcase
            dat = (vld && k < 33) ? coef[k] : 16'($urandom);
            upd = s.upd_wr && ready_e(n) && $urandom_range(0, 3) == 0;
            step(0, upd, vld, dat);
            guard++;
        end
        chk("scn_bound", guard >= 3000, 0);
        repeat (3) step(0, 0, s.vld_idle ? 1'($urandom) : 1'b0, 16'($urandom));
        chk("scn_writes", wr_seen - wr0, s.exp_wr);
        chk("scn_done", done_seen - dn0, s.exp_done);
        chk("scn_err", oErr, s.exp_err);
    endtask

    initial begin
        int first, pulses, guard;
        tbl[0] = '{0, 0, 0, 33, 1, 0};
        tbl[1] = '{1, 0, 0, 33, 1, 0};
        tbl[2] = '{2, 0, 0, 10, 0, 1};
        tbl[3] = '{0, 1, 1, 33, 1, 0};
        for (int i = 4; i < 8; i++) tbl[i] = '{3, 1, 1, 33, 1, 0};

        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);

        // Free-running strobe grid out of reset.
        first = -1;
        pulses = 0;
        repeat (200) begin
            step(0, 0, 0, 16'h0);
            if (oEnSample_300k === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        chk("first_strobe", first, 39);
        chk("strobe_count", pulses, 5);

        for (int i = 0; i < 8; i++) run_scn(tbl[i]);

        // Reset in the middle of a reload after 20 handshakes.
        step(0, 1, 0, 16'h0);
        guard = 0;
        while (k < 20 && guard < 500) begin
            step(0, 0, 1, 16'(k + 100));
            guard++;
        end
        chk("rst_k", k, 20);
        step(1, 0, 1, 16'h0);
        chk("rst_csn", oCsnRam, 1);
        chk("rst_busy", oBusy, 0);
        chk("rst_flag", oCoeffiUpdateFlag, 0);
        first = -1;
        repeat (45) begin
            step(0, 0, 0, 16'h0);
            if (oEnSample_300k === 1'b1 && first < 0) first = n;
        end
        chk("rst_first_strobe", first, 39);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
